// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller between DOF and EX: hold enables, bubbles, watchdog.
// Optional STALL_PERF_CNT_EN adds an 8-bit saturating stall-cycle counter.
module pipeline_stall_ctrl #(
    parameter int MAX_STALL = 4,
    parameter int CW        = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          DHS,
    input  logic          BR_TAKEN,
    input  logic [2:0]    DA,
    input  logic          RW,
    input  logic          MW,
    output logic          PC_EN,
    output logic          IR_EN,
    output logic          IR_FLUSH,
    output logic [2:0]    EX_DA,
    output logic          EX_RW,
    output logic          EX_MW,
    output logic          BUBBLE,
`ifdef STALL_PERF_CNT_EN
    output logic [7:0]    STALL_CNT,
`endif
    output logic          STALL_ERR
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] STALL_LIM = CW'(MAX_STALL);

    logic [1:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          active;
    logic          load;

    always_comb begin
        active   = !rst && (state != S_HALT);
        PC_EN    = active && (BR_TAKEN || DHS);
        IR_EN    = active && (BR_TAKEN || DHS);
        IR_FLUSH = active && BR_TAKEN;
        // only a clean advance with no flush passes DOF controls to EX
        load     = (state != S_HALT) && !BR_TAKEN && DHS;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state != S_HALT) begin
            if (BR_TAKEN || DHS) begin
                state_nx = S_RUN;
                cnt_nx   = '0;
            end else if (cnt == STALL_LIM) begin
                state_nx = S_HALT;
            end else begin
                state_nx = S_STALL;
                if (cnt != CNT_MAX)
                    cnt_nx = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RUN;
            cnt       <= '0;
            EX_DA     <= 3'b000;
            EX_RW     <= 1'b0;
            EX_MW     <= 1'b0;
            BUBBLE    <= 1'b1;
            STALL_ERR <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            EX_DA  <= load ? DA : 3'b000;
            EX_RW  <= load && RW;
            EX_MW  <= load && MW;
            BUBBLE <= !load;
            if (state_nx == S_HALT)
                STALL_ERR <= 1'b1;
        end
    end

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            STALL_CNT <= 8'h00;
        else if (!PC_EN && (STALL_CNT != 8'hFF))
            STALL_CNT <= STALL_CNT + 8'h01;
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: vector table, hand sequences,
// and randomized traffic against a cycle-level reference model.
module tb_pipeline_stall_ctrl;

    localparam int MAX_STALL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       DHS, BR_TAKEN, RW, MW;
    logic [2:0] DA;
    logic       PC_EN, IR_EN, IR_FLUSH;
    logic [2:0] EX_DA;
    logic       EX_RW, EX_MW, BUBBLE, STALL_ERR;
`ifdef STALL_PERF_CNT_EN
    logic [7:0] STALL_CNT;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MAX_STALL(MAX_STALL), .CW(3)) dut (
        .clk(clk), .rst(rst), .DHS(DHS), .BR_TAKEN(BR_TAKEN),
        .DA(DA), .RW(RW), .MW(MW),
        .PC_EN(PC_EN), .IR_EN(IR_EN), .IR_FLUSH(IR_FLUSH),
        .EX_DA(EX_DA), .EX_RW(EX_RW), .EX_MW(EX_MW),
        .BUBBLE(BUBBLE),
`ifdef STALL_PERF_CNT_EN
        .STALL_CNT(STALL_CNT),
`endif
        .STALL_ERR(STALL_ERR)
    );

    typedef struct {
        logic       dhs, br;
        logic [2:0] da;
        logic       rw, mw;
        logic       pc, fl;
        logic [2:0] xda;
        logic       xrw, xmw, bub, err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic dhs, br, input logic [2:0] da,
                       input logic rw, mw, pc, fl, input logic [2:0] xda,
                       input logic xrw, xmw, bub, err);
        vec_t v;
        v.dhs = dhs; v.br = br; v.da = da; v.rw = rw; v.mw = mw;
        v.pc = pc; v.fl = fl; v.xda = xda; v.xrw = xrw; v.xmw = xmw;
        v.bub = bub; v.err = err;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic dhs, br, input logic [2:0] da,
                         input logic rw, mw);
        DHS = dhs; BR_TAKEN = br; DA = da; RW = rw; MW = mw;
    endtask

    task automatic chk_regs(input string p, input logic [2:0] xda,
                            input logic xrw, xmw, bub, err);
        chk({p, ".ex_da"}, 8'(EX_DA), 8'(xda));
        chk({p, ".ex_rw"}, 8'(EX_RW), 8'(xrw));
        chk({p, ".ex_mw"}, 8'(EX_MW), 8'(xmw));
        chk({p, ".bubble"}, 8'(BUBBLE), 8'(bub));
        chk({p, ".stall_err"}, 8'(STALL_ERR), 8'(err));
    endtask

    // Reset held across one edge; called at posedge+1, returns at posedge+1.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst.pc_en", 8'(PC_EN), 8'd0);
        chk("rst.ir_flush", 8'(IR_FLUSH), 8'd0);
        chk_regs("rst", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reference model: counts consecutive stall cycles as an integer.
    int   m_run;
    bit   m_halt, m_err, m_bub, m_rw, m_mw;
    int   m_da;
    int   m_perf;

    function automatic bit m_pc();
        return !rst && !m_halt && (BR_TAKEN || DHS);
    endfunction

    task automatic m_clear();
        m_run = 0; m_halt = 0; m_err = 0; m_bub = 1;
        m_rw = 0; m_mw = 0; m_da = 0; m_perf = 0;
    endtask

    task automatic m_edge();
        bit pc;
        pc = m_pc();
        if (rst) begin
            m_clear();
            return;
        end
        if (!pc && m_perf < 255) m_perf++;
        m_bub = 1; m_da = 0; m_rw = 0; m_mw = 0;
        if (m_halt) return;
        if (BR_TAKEN) begin
            m_run = 0;
        end else if (DHS) begin
            m_run = 0; m_bub = 0; m_da = DA; m_rw = RW; m_mw = MW;
        end else if (m_run + 1 > MAX_STALL) begin
            m_halt = 1; m_err = 1;
        end else begin
            m_run++;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        #1;
        chk("por.pc_en", 8'(PC_EN), 8'd0);
        @(posedge clk);
        #1;
        do_reset();

        add(1, 0, 3'd3, 1, 0, 1, 0, 3'd3, 1, 0, 0, 0);
        add(0, 0, 3'd5, 1, 0, 0, 0, 3'd0, 0, 0, 1, 0);
        add(0, 0, 3'd5, 1, 0, 0, 0, 3'd0, 0, 0, 1, 0);
        add(1, 0, 3'd5, 1, 0, 1, 0, 3'd5, 1, 0, 0, 0);
        add(0, 1, 3'd2, 1, 0, 1, 1, 3'd0, 0, 0, 1, 0);
        add(1, 0, 3'd2, 1, 1, 1, 0, 3'd2, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 3'd4, 1, 1, 0, 0, 3'd0, 0, 0, 1, 0);
        add(0, 0, 3'd4, 1, 1, 0, 0, 3'd0, 0, 0, 1, 1);
        add(0, 0, 3'd4, 1, 1, 0, 0, 3'd0, 0, 0, 1, 1);
        add(1, 1, 3'd6, 1, 1, 0, 0, 3'd0, 0, 0, 1, 1);
        add(1, 0, 3'd6, 1, 1, 0, 0, 3'd0, 0, 0, 1, 1);

        foreach (tbl[i]) begin
            string p;
            p = $sformatf("vec%0d", i);
            drive(tbl[i].dhs, tbl[i].br, tbl[i].da, tbl[i].rw, tbl[i].mw);
            #2;
            chk({p, ".pc_en"}, 8'(PC_EN), 8'(tbl[i].pc));
            chk({p, ".ir_en"}, 8'(IR_EN), 8'(tbl[i].pc));
            chk({p, ".ir_flush"}, 8'(IR_FLUSH), 8'(tbl[i].fl));
            @(posedge clk);
            #1;
            chk_regs(p, tbl[i].xda, tbl[i].xrw, tbl[i].xmw,
                     tbl[i].bub, tbl[i].err);
        end

        // In HALT: async reset clears the sticky error without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("halt_rst.stall_err", 8'(STALL_ERR), 8'd0);
        chk("halt_rst.pc_en", 8'(PC_EN), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load EX, then stall; reset lands mid-way through stall 2 of 3.
        drive(1'b1, 1'b0, 3'd7, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("pre.ex_da", 8'(EX_DA), 8'd7);
        drive(1'b0, 1'b0, 3'd7, 1'b1, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_regs("midrst", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst.pc_en", 8'(PC_EN), 8'd1);
        @(posedge clk);
        #1;
        chk("post_rst.ex_da", 8'(EX_DA), 8'd1);

        // Async reset from a loaded EX register clears it immediately.
        #2;
        rst = 1'b1;
        #1;
        chk_regs("ldrst", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef STALL_PERF_CNT_EN
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i == 3)
                drive(1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
            else
                drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        #1;
        chk("perf.stall_cnt", STALL_CNT, 8'd5);
        @(posedge clk);
        #1;
`endif

        // Randomized traffic against the model.
        do_reset();
        m_clear();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            #2;
            chk("rnd.pc_en", 8'(PC_EN), 8'(m_pc()));
            chk("rnd.ir_en", 8'(IR_EN), 8'(m_pc()));
            chk("rnd.ir_flush", 8'(IR_FLUSH),
                8'(!rst && !m_halt && BR_TAKEN));
            @(posedge clk);
            m_edge();
            #1;
            chk_regs("rnd", 3'(m_da), m_rw, m_mw, m_bub, m_err);
`ifdef STALL_PERF_CNT_EN
            chk("rnd.stall_cnt", STALL_CNT, 8'(m_perf));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
